// File: rtl/shiftreg_sequencer.sv
// ---------------------------------------------------------------------------
// shiftreg_sequencer
//   Start/busy/done controller that programs the static and dynamic shift-
//   register chains of the signal generator. An accepted START snapshots both
//   configuration words. The controller then shifts the static chain (unless
//   DYN_ONLY) and the dynamic chain MSB-first on a divided serial clock, and
//   pulses the matching latch after each chain. It signals completion with a
//   one-cycle ENFIN pulse.
//
// Ports
//   CLK        system clock, rising edge
//   RST        synchronous reset, active-high
//   START      transfer request, honoured only in IDLE
//   DYN_ONLY   sampled with START; 1 = skip the static chain
//   ABORT      cancel a transfer in progress (also blocks START in IDLE)
//   STAT_DATA  static chain word, captured on accepted START
//   DYN_DATA   dynamic chain word, captured on accepted START
//   SDATA      serial data to the selected chain
//   SCLK       serial shift clock
//   SELSTAT    static chain selected
//   SELDYN     dynamic chain selected
//   STATLATCH  static latch pulse (DIV cycles)
//   DYNLATCH   dynamic latch pulse (DIV cycles)
//   BUSY       any non-IDLE state
//   ENFIN      one-cycle completion pulse
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | waiting for START
// STAT_SHIFT | shifting SIZESRSTAT bits into the static chain
// STAT_LATCH | STATLATCH high for DIV cycles
// DYN_SHIFT  | shifting SIZESRDYN bits into the dynamic chain
// DYN_LATCH  | DYNLATCH high for DIV cycles
// FINISH     | ENFIN pulse, back to IDLE
// ---------------------------------------------------------------------------
module shiftreg_sequencer #(
  parameter int SIZESRSTAT = 88,
  parameter int SIZESRDYN  = 16,
  parameter int DIV        = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  DYN_ONLY,
  input  logic                  ABORT,
  input  logic [SIZESRSTAT-1:0] STAT_DATA,
  input  logic [SIZESRDYN-1:0]  DYN_DATA,
  output logic                  SDATA,
  output logic                  SCLK,
  output logic                  SELSTAT,
  output logic                  SELDYN,
  output logic                  STATLATCH,
  output logic                  DYNLATCH,
  output logic                  BUSY,
  output logic                  ENFIN
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] STAT_SHIFT = 3'd1;
  localparam logic [2:0] STAT_LATCH = 3'd2;
  localparam logic [2:0] DYN_SHIFT  = 3'd3;
  localparam logic [2:0] DYN_LATCH  = 3'd4;
  localparam logic [2:0] FINISH     = 3'd5;

  localparam int MAX_SZ = (SIZESRSTAT > SIZESRDYN) ? SIZESRSTAT : SIZESRDYN;
  localparam int BW     = $clog2(MAX_SZ + 1);
  localparam int PW     = $clog2(2 * DIV);

  localparam logic [BW-1:0] BITS_STAT = BW'(SIZESRSTAT - 1);
  localparam logic [BW-1:0] BITS_DYN  = BW'(SIZESRDYN - 1);
  localparam logic [PW-1:0] PH_BIT    = PW'(2 * DIV - 1);
  localparam logic [PW-1:0] PH_LAT    = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_HALF   = PW'(DIV);

  logic [2:0]            state;
  logic [PW-1:0]         phase;    // down-counter within a bit or latch pulse
  logic [BW-1:0]         bit_cnt;  // bits remaining after the current one
  logic [SIZESRSTAT-1:0] stat_sh;
  logic [SIZESRDYN-1:0]  dyn_sh;

  logic phase_tc;
  logic bit_tc;

  assign phase_tc = (phase == '0);
  assign bit_tc   = (bit_cnt == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      stat_sh <= '0;
      dyn_sh  <= '0;
    end else if (ABORT && (state != IDLE)) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START && !ABORT) begin
            stat_sh <= STAT_DATA;
            dyn_sh  <= DYN_DATA;
            phase   <= PH_BIT;
            if (DYN_ONLY) begin
              state   <= DYN_SHIFT;
              bit_cnt <= BITS_DYN;
            end else begin
              state   <= STAT_SHIFT;
              bit_cnt <= BITS_STAT;
            end
          end
        end
        STAT_SHIFT: begin
          if (phase_tc) begin
            stat_sh <= stat_sh << 1;
            if (bit_tc) begin
              state <= STAT_LATCH;
              phase <= PH_LAT;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              phase   <= PH_BIT;
            end
          end else begin
            phase <= phase - 1'b1;
          end
        end
        STAT_LATCH: begin
          if (phase_tc) begin
            state   <= DYN_SHIFT;
            phase   <= PH_BIT;
            bit_cnt <= BITS_DYN;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        DYN_SHIFT: begin
          if (phase_tc) begin
            dyn_sh <= dyn_sh << 1;
            if (bit_tc) begin
              state <= DYN_LATCH;
              phase <= PH_LAT;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              phase   <= PH_BIT;
            end
          end else begin
            phase <= phase - 1'b1;
          end
        end
        DYN_LATCH: begin
          if (phase_tc) begin
            state <= FINISH;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only. The phase counter runs down, so the
  // low half of the bit is the upper count range.
  always_comb begin
    SDATA     = 1'b0;
    SCLK      = 1'b0;
    SELSTAT   = 1'b0;
    SELDYN    = 1'b0;
    STATLATCH = 1'b0;
    DYNLATCH  = 1'b0;
    ENFIN     = 1'b0;
    BUSY      = (state != IDLE);
    case (state)
      STAT_SHIFT: begin
        SELSTAT = 1'b1;
        SDATA   = stat_sh[SIZESRSTAT-1];
        SCLK    = (phase < PH_HALF);
      end
      STAT_LATCH: STATLATCH = 1'b1;
      DYN_SHIFT: begin
        SELDYN = 1'b1;
        SDATA  = dyn_sh[SIZESRDYN-1];
        SCLK   = (phase < PH_HALF);
      end
      DYN_LATCH: DYNLATCH = 1'b1;
      FINISH:    ENFIN = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shiftreg_sequencer.sv
module tb_shiftreg_sequencer;

  localparam int B_SDATA = 7, B_SCLK = 6, B_SELSTAT = 5, B_SELDYN = 4;
  localparam int B_SLAT = 3, B_DLAT = 2, B_BUSY = 1, B_ENFIN = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, dyn_only, sel3;
  logic [87:0] stat_data;
  logic [15:0] dyn_data;

  wire start1 = start & ~sel3;
  wire start3 = start & sel3;

  logic s1_sdata, s1_sclk, s1_selstat, s1_seldyn, s1_slat, s1_dlat, s1_busy, s1_enfin;
  logic s3_sdata, s3_sclk, s3_selstat, s3_seldyn, s3_slat, s3_dlat, s3_busy, s3_enfin;

  shiftreg_sequencer #(.SIZESRSTAT(88), .SIZESRDYN(16), .DIV(1)) dut1 (
    .CLK(clk), .RST(rst), .START(start1), .DYN_ONLY(dyn_only), .ABORT(abort),
    .STAT_DATA(stat_data), .DYN_DATA(dyn_data),
    .SDATA(s1_sdata), .SCLK(s1_sclk), .SELSTAT(s1_selstat), .SELDYN(s1_seldyn),
    .STATLATCH(s1_slat), .DYNLATCH(s1_dlat), .BUSY(s1_busy), .ENFIN(s1_enfin)
  );

  shiftreg_sequencer #(.SIZESRSTAT(88), .SIZESRDYN(16), .DIV(3)) dut3 (
    .CLK(clk), .RST(rst), .START(start3), .DYN_ONLY(dyn_only), .ABORT(abort),
    .STAT_DATA(stat_data), .DYN_DATA(dyn_data),
    .SDATA(s3_sdata), .SCLK(s3_sclk), .SELSTAT(s3_selstat), .SELDYN(s3_seldyn),
    .STATLATCH(s3_slat), .DYNLATCH(s3_dlat), .BUSY(s3_busy), .ENFIN(s3_enfin)
  );

  wire [7:0] o1  = {s1_sdata, s1_sclk, s1_selstat, s1_seldyn, s1_slat, s1_dlat, s1_busy, s1_enfin};
  wire [7:0] o3  = {s3_sdata, s3_sclk, s3_selstat, s3_seldyn, s3_slat, s3_dlat, s3_busy, s3_enfin};
  wire [7:0] mon = sel3 ? o3 : o1;

  int checks = 0;
  int errors = 0;

  logic [7:0]  out_log [0:511];
  logic [87:0] stat_rx;
  logic [15:0] dyn_rx;
  int          n_rs, n_rd;
  int          f_first [8];
  int          f_cnt   [8];
  int          f_last  [8];
  int          both_sel, idle_bad;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller raises START (and sets data) before calling; the next edge is edge 0.
  task automatic run(input int n, input int abort_at, input int rst_at,
                     input int poke_at, input bit hold);
    logic prev_sclk;
    prev_sclk = 1'b0;
    stat_rx = '0; dyn_rx = '0; n_rs = 0; n_rd = 0;
    tick();
    start = hold;
    for (int c = 1; c <= n; c++) begin
      out_log[c] = mon;
      if (mon[B_SCLK] && !prev_sclk) begin
        if (mon[B_SELSTAT]) begin stat_rx = {stat_rx[86:0], mon[B_SDATA]}; n_rs++; end
        if (mon[B_SELDYN])  begin dyn_rx  = {dyn_rx[14:0],  mon[B_SDATA]}; n_rd++; end
      end
      prev_sclk = mon[B_SCLK];
      abort = (c == abort_at);
      rst   = (c == rst_at);
      if (c == poke_at) begin
        start = 1'b1;
        stat_data = '0;
      end else begin
        start = hold;
      end
      tick();
    end
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic analyze(input int n);
    both_sel = 0; idle_bad = 0;
    for (int b = 0; b < 8; b++) begin f_first[b] = 0; f_cnt[b] = 0; f_last[b] = 0; end
    for (int c = 1; c <= n; c++) begin
      for (int b = 0; b < 8; b++) begin
        if (out_log[c][b]) begin
          if (f_cnt[b] == 0) f_first[b] = c;
          f_cnt[b]++;
          f_last[b] = c;
        end
      end
      if (out_log[c][B_SELSTAT] && out_log[c][B_SELDYN]) both_sel++;
      if (!out_log[c][B_SELSTAT] && !out_log[c][B_SELDYN] &&
          (out_log[c][B_SDATA] || out_log[c][B_SCLK])) idle_bad++;
    end
  endtask

  initial begin
    logic [5:0] sclk_pat;
    rst = 1'b1; start = 1'b0; abort = 1'b0; dyn_only = 1'b0; sel3 = 1'b0;
    stat_data = 88'hABCDEF123456789ABCDEF1;
    dyn_data  = 16'h1234;
    tick(); tick();
    check_eq("reset_out_div1", o1, 8'h00);
    check_eq("reset_out_div3", o3, 8'h00);
    rst = 1'b0;
    tick();

    // Full transfer; STAT_DATA changed and START pulsed mid-transfer.
    start = 1'b1;
    run(215, 0, 0, 20, 1'b0);
    analyze(215);
    check_eq("full_stat_data", stat_rx, 88'hABCDEF123456789ABCDEF1);
    check_eq("full_stat_bits", n_rs, 88);
    check_eq("full_dyn_data", dyn_rx, 16'h1234);
    check_eq("full_dyn_bits", n_rd, 16);
    check_eq("full_slat_first", f_first[B_SLAT], 177);
    check_eq("full_slat_cnt", f_cnt[B_SLAT], 1);
    check_eq("full_dlat_first", f_first[B_DLAT], 210);
    check_eq("full_dlat_cnt", f_cnt[B_DLAT], 1);
    check_eq("full_enfin_first", f_first[B_ENFIN], 211);
    check_eq("full_enfin_cnt", f_cnt[B_ENFIN], 1);
    check_eq("full_busy_first", f_first[B_BUSY], 1);
    check_eq("full_busy_last", f_last[B_BUSY], 211);
    check_eq("full_busy_cnt", f_cnt[B_BUSY], 211);
    check_eq("full_both_sel", both_sel, 0);
    check_eq("full_idle_quiet", idle_bad, 0);

    // Dynamic only, DIV=1.
    stat_data = 88'hABCDEF123456789ABCDEF1;
    dyn_only = 1'b1; dyn_data = 16'h8001; start = 1'b1;
    run(40, 0, 0, 0, 1'b0);
    analyze(40);
    check_eq("dyn_selstat_cnt", f_cnt[B_SELSTAT], 0);
    check_eq("dyn_data", dyn_rx, 16'h8001);
    check_eq("dyn_bits", n_rd, 16);
    check_eq("dyn_dlat_first", f_first[B_DLAT], 33);
    check_eq("dyn_dlat_cnt", f_cnt[B_DLAT], 1);
    check_eq("dyn_enfin_first", f_first[B_ENFIN], 34);
    check_eq("dyn_idle_quiet", idle_bad, 0);

    // Dynamic only, DIV=3.
    sel3 = 1'b1; dyn_data = 16'hA5C3; start = 1'b1;
    run(105, 0, 0, 0, 1'b0);
    analyze(105);
    sclk_pat = {out_log[1][B_SCLK], out_log[2][B_SCLK], out_log[3][B_SCLK],
                out_log[4][B_SCLK], out_log[5][B_SCLK], out_log[6][B_SCLK]};
    check_eq("div3_sclk_pattern", sclk_pat, 6'b000111);
    check_eq("div3_sclk_cnt", f_cnt[B_SCLK], 48);
    check_eq("div3_data", dyn_rx, 16'hA5C3);
    check_eq("div3_dlat_first", f_first[B_DLAT], 97);
    check_eq("div3_dlat_cnt", f_cnt[B_DLAT], 3);
    check_eq("div3_enfin_first", f_first[B_ENFIN], 100);
    check_eq("div3_enfin_cnt", f_cnt[B_ENFIN], 1);
    sel3 = 1'b0; dyn_only = 1'b0; dyn_data = 16'h1234;

    // Abort at cycle 50, then a clean transfer.
    start = 1'b1;
    run(215, 50, 0, 0, 1'b0);
    analyze(215);
    check_eq("abort_busy_last", f_last[B_BUSY], 50);
    check_eq("abort_out_51", out_log[51], 8'h00);
    check_eq("abort_slat_cnt", f_cnt[B_SLAT], 0);
    check_eq("abort_dlat_cnt", f_cnt[B_DLAT], 0);
    check_eq("abort_enfin_cnt", f_cnt[B_ENFIN], 0);
    start = 1'b1;
    run(215, 0, 0, 0, 1'b0);
    analyze(215);
    check_eq("after_abort_enfin", f_first[B_ENFIN], 211);
    check_eq("after_abort_data", stat_rx, 88'hABCDEF123456789ABCDEF1);

    // START held high: re-accepted in the IDLE cycle after FINISH.
    start = 1'b1;
    run(214, 0, 0, 0, 1'b1);
    analyze(214);
    check_eq("hold_enfin_first", f_first[B_ENFIN], 211);
    check_eq("hold_busy_211", out_log[211][B_BUSY], 1'b1);
    check_eq("hold_busy_212", out_log[212][B_BUSY], 1'b0);
    check_eq("hold_busy_213", out_log[213][B_BUSY], 1'b1);
    start = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    check_eq("hold_reset_out", o1, 8'h00);

    // Reset during STAT_LATCH.
    start = 1'b1;
    run(215, 0, 177, 0, 1'b0);
    analyze(215);
    check_eq("rst_in_slat", out_log[177][B_SLAT], 1'b1);
    check_eq("rst_out_178", out_log[178], 8'h00);
    check_eq("rst_busy_last", f_last[B_BUSY], 177);
    check_eq("rst_dlat_cnt", f_cnt[B_DLAT], 0);
    check_eq("rst_enfin_cnt", f_cnt[B_ENFIN], 0);

    // START and ABORT together in IDLE.
    start = 1'b1; abort = 1'b1;
    tick();
    check_eq("start_abort_busy1", o1[B_BUSY], 1'b0);
    tick();
    check_eq("start_abort_busy2", o1[B_BUSY], 1'b0);
    start = 1'b0; abort = 1'b0;
    tick();
    check_eq("start_abort_idle", o1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
